turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Sequences play between the two move sources of the Go engine (player 0 = black, player 1 = white) and owns the single write port into the 9x9 board store. It grants one player at a time and registers that player's move or pass. It checks the target cell against the board, then commits the stone and hands off to the capture engine. Once capture resolution completes it passes the turn to the other player. It also detects end of game (two consecutive passes). It sits between the per-player input blocks (local cursor I/O, remote link) and the board/capture datapath.

## Interface
- TIMEOUT_CYCLES, default 32'd100_000_000: per-turn move timeout, used only when TURN_TIMEOUT_EN is defined.
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-high.
- move_valid  input  [1:0]  per-player move strobe; bit p belongs to player p.
- move_in0, move_in1  input  [7:0] each  move from player 0 and player 1; [7:4] row, [3:0] col.
- pass_in  input  [1:0]  per-player pass strobe.
- board  input  [1:0] [8:0][8:0]  current board; 00 empty, 01 black, 10 white, 11 reserved.
- capture_done  input  1  capture engine finished resolving the last placed stone.
- my_turn  output  [1:0]  one-hot grant to the player allowed to move; 00 outside WAIT_MOVE.
- board_we  output  1  single-cycle board write strobe.
- board_row, board_col  output  [3:0] each  write address.
- board_val  output  [1:0]  stone written (01 or 10).
- capture_start  output  1  single-cycle pulse to the capture engine.
- illegal  output  1  single-cycle pulse when a move is rejected.
- timeout  output  1  single-cycle pulse on a forced pass; tied 0 without TURN_TIMEOUT_EN.
- game_over  output  1  sticky end-of-game flag.
- cur_player  output  1  player whose turn it is.
- move_count  output  [7:0]  placed stones; saturates at 255.

## Operation
- One-hot FSM states: WAIT_MOVE, CHECK, WRITE, CAPTURE, SWITCH, GAME_OVER.
- Reset state: WAIT_MOVE with cur_player=0. All pulse outputs are 0, game_over=0, move_count=0, and the pass streak is 0.
- WAIT_MOVE:
  - my_turn[cur_player] is 1.
  - Strobes from the non-current player are ignored.
  - pass_in[cur] moves to SWITCH with pass streak +1. If the streak was already 1, it moves to GAME_OVER instead.
  - Else move_valid[cur] latches the move into an internal register and moves to CHECK.
  - If pass and move arrive in the same cycle, the pass wins.
- CHECK: the move is legal when row<9, col<9 and board[row][col]==00.
  - Legal: go to WRITE.
  - Illegal: pulse illegal and return to WAIT_MOVE with the same player; the pass streak is unchanged.
- WRITE:
  - board_we=1; board_row, board_col and board_val are driven for exactly this cycle.
  - Clear the pass streak and increment move_count, saturating at 255.
  - Go to CAPTURE.
- CAPTURE:
  - capture_start pulses on the first cycle only.
  - Hold until capture_done, then go to SWITCH.
  - capture_done seen in any other state is ignored.
- SWITCH: toggle cur_player, then go to WAIT_MOVE.
- GAME_OVER: game_over=1, my_turn=00; no further moves or passes are accepted. It is left only by reset.
- Reset in any state, including mid-CAPTURE, returns to the reset state on the next edge; board_we and capture_start are 0 on the cycle after reset is asserted.

## Timing
- Move strobe in WAIT_MOVE at cycle N:
  - CHECK at N+1.
  - board_we at N+2.
  - capture_start at N+3.
- capture_done at cycle M puts SWITCH at M+1; the other player's my_turn rises at M+2.
- Illegal move: illegal pulses at N+1; my_turn is high again at N+2.
- Pass at cycle N: SWITCH at N+1; the other player's my_turn rises at N+2.
- my_turn is low for at least 1 cycle between players. This gives each input block a "locked" observation.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

## Configuration
- TURN_TIMEOUT_EN defined:
  - A counter runs only in WAIT_MOVE and clears on entry.
  - At TIMEOUT_CYCLES-1 the sequencer treats the cycle as pass_in[cur]: timeout pulses and the pass streak rules apply.
  - The counter is 32 bits and never wraps before comparison.
- TURN_TIMEOUT_EN undefined: no counter is built, timeout is tied 0, and a player may wait indefinitely.

## Structure
- go_pkg holds:
  - BOARD_N=9.
  - The cell typedef (EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10).
  - The player typedef.
  - The move-field helpers (row/col slice).
  - The sequencer state typedef.
- One sub-module, turn_timer (load, enable, expire pulse), instantiated only under TURN_TIMEOUT_EN.

## Test plan
- Player 0 moves 8'h44 on an empty board: board_we at N+2 with row=4, col=4, val=01; capture_start at N+3; capture_done gives my_turn=10 two cycles later.
- Player 1 moves onto occupied 8'h44: illegal pulses once, no board_we, my_turn stays 10.
- Player 0 moves 8'h93 (row 9): illegal; move 8'h09 (col 9): illegal.
- Pass by player 0, then pass by player 1: game_over=1, my_turn=00; later strobes are ignored.
- Pass, then a stone move, then a pass: no game_over, because the stone cleared the streak; move_count=1.
- With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=16, no input: timeout at cycle 15 of WAIT_MOVE and the turn passes. A second timeout gives game_over.
- Reset asserted during CAPTURE: cur_player=0, my_turn=01, move_count=0 on the next cycle; a late capture_done is ignored.

Source files
------------

// File: rtl/go_pkg.sv
// rtl/go_pkg.sv - shared Go board types, move-field helpers and sequencer states
package go_pkg;

  localparam int BOARD_N = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  typedef enum logic {
    PLAYER_BLACK = 1'b0,
    PLAYER_WHITE = 1'b1
  } player_t;

  typedef enum logic [5:0] {
    WAIT_MOVE = 6'b000001,
    CHECK     = 6'b000010,
    WRITE     = 6'b000100,
    CAPTURE   = 6'b001000,
    SWITCH    = 6'b010000,
    GAME_OVER = 6'b100000
  } seq_state_t;

  function automatic logic [3:0] move_row(input logic [7:0] m);
    return m[7:4];
  endfunction

  function automatic logic [3:0] move_col(input logic [7:0] m);
    return m[3:0];
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// rtl/turn_sequencer_if.sv - player-side move/pass/grant signals of the turn sequencer
interface turn_sequencer_if;
  logic [1:0] move_valid;
  logic [7:0] move_in0;
  logic [7:0] move_in1;
  logic [1:0] pass_in;
  logic [1:0] my_turn;
  logic       illegal;
  logic       timeout;

  modport master (
    output move_valid, move_in0, move_in1, pass_in,
    input  my_turn, illegal, timeout
  );

  modport slave (
    input  move_valid, move_in0, move_in1, pass_in,
    output my_turn, illegal, timeout
  );
endinterface

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn idle counter; expire is high on the TIMEOUT_CYCLES-1 count
module turn_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  logic [31:0] count;

  // Counting stops at expiry so the 32-bit counter can never wrap past the compare.
  always_ff @(posedge clk_in) begin
    if (reset || load) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 32'd1;
    end
  end

  assign expire = enable && (count == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - grants turns, validates and commits moves, detects end of game; TURN_TIMEOUT_EN adds forced passes
module turn_sequencer
  import go_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  turn_sequencer_if.slave       pif,
  input  logic [8:0][8:0][1:0]  board,
  input  logic                  capture_done,
  output logic                  board_we,
  output logic [3:0]            board_row,
  output logic [3:0]            board_col,
  output logic [1:0]            board_val,
  output logic                  capture_start,
  output logic                  game_over,
  output logic                  cur_player,
  output logic [7:0]            move_count
);

  seq_state_t state, state_nxt;
  player_t    cur_q;
  logic       pass_streak;
  logic [7:0] move_q;
  logic       legal_q;
  logic       capture_start_q;
  logic [7:0] move_count_q;
  logic       timeout_hit;
  logic [7:0] cur_move;
  logic       cur_valid;
  logic       cur_pass;
  logic       legal_now;

`ifdef TURN_TIMEOUT_EN
  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (state != WAIT_MOVE),
    .enable (state == WAIT_MOVE),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign cur_move  = (cur_q == PLAYER_WHITE) ? pif.move_in1 : pif.move_in0;
  assign cur_valid = pif.move_valid[cur_q];
  assign cur_pass  = pif.pass_in[cur_q] || timeout_hit;

  // Legality is judged while the move is latched so CHECK decodes only registered state.
  always_comb begin
    legal_now = 1'b0;
    if (move_row(cur_move) < 4'(BOARD_N) && move_col(cur_move) < 4'(BOARD_N)) begin
      legal_now = (board[move_row(cur_move)][move_col(cur_move)] == EMPTY);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= WAIT_MOVE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_MOVE: begin
        if (cur_pass) begin
          state_nxt = pass_streak ? GAME_OVER : SWITCH;
        end else if (cur_valid) begin
          state_nxt = CHECK;
        end
      end
      CHECK:     state_nxt = legal_q ? WRITE : WAIT_MOVE;
      WRITE:     state_nxt = CAPTURE;
      CAPTURE:   if (capture_done) state_nxt = SWITCH;
      SWITCH:    state_nxt = WAIT_MOVE;
      GAME_OVER: state_nxt = GAME_OVER;
      default:   state_nxt = WAIT_MOVE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cur_q           <= PLAYER_BLACK;
      pass_streak     <= 1'b0;
      move_q          <= '0;
      legal_q         <= 1'b0;
      capture_start_q <= 1'b0;
      move_count_q    <= '0;
    end else begin
      capture_start_q <= (state == WRITE);
      if (state == WAIT_MOVE) begin
        if (cur_pass) begin
          pass_streak <= 1'b1;
        end else if (cur_valid) begin
          move_q  <= cur_move;
          legal_q <= legal_now;
        end
      end
      if (state == WRITE) begin
        pass_streak <= 1'b0;
        if (move_count_q != 8'hFF) begin
          move_count_q <= move_count_q + 8'd1;
        end
      end
      if (state == SWITCH) begin
        cur_q <= (cur_q == PLAYER_WHITE) ? PLAYER_BLACK : PLAYER_WHITE;
      end
    end
  end

  assign pif.my_turn  = (state != WAIT_MOVE) ? 2'b00 :
                        (cur_q == PLAYER_WHITE) ? 2'b10 : 2'b01;
  assign pif.illegal  = (state == CHECK) && !legal_q;
  assign pif.timeout  = timeout_hit;
  assign board_we     = (state == WRITE);
  assign board_row    = move_row(move_q);
  assign board_col    = move_col(move_q);
  assign board_val    = (cur_q == PLAYER_WHITE) ? WHITE : BLACK;
  assign capture_start = capture_start_q;
  assign game_over    = (state == GAME_OVER);
  assign cur_player   = cur_q;
  assign move_count   = move_count_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
module tb_turn_sequencer;

  logic clk_in = 1'b0;
  logic reset;
  logic [8:0][8:0][1:0] board;
  logic capture_done;
  logic board_we;
  logic [3:0] board_row, board_col;
  logic [1:0] board_val;
  logic capture_start, game_over, cur_player;
  logic [7:0] move_count;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  turn_sequencer_if pif ();

  turn_sequencer #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .pif           (pif),
    .board         (board),
    .capture_done  (capture_done),
    .board_we      (board_we),
    .board_row     (board_row),
    .board_col     (board_col),
    .board_val     (board_val),
    .capture_start (capture_start),
    .game_over     (game_over),
    .cur_player    (cur_player),
    .move_count    (move_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_strobes;
    pif.move_valid = 2'b00;
    pif.pass_in    = 2'b00;
    capture_done   = 1'b0;
  endtask

  task automatic drive_move(input int p, input logic [7:0] mv);
    if (p == 0) pif.move_in0 = mv;
    else        pif.move_in1 = mv;
    pif.move_valid[p] = 1'b1;
  endtask

  task automatic place(input string tag, input int p, input logic [7:0] mv, input logic [7:0] exp_count);
    logic [3:0] r, c;
    r = mv[7:4];
    c = mv[3:0];
    drive_move(p, mv);
    tick;
    clear_strobes;
    check({tag, "_chk_ill"}, pif.illegal, 0);
    check({tag, "_chk_turn"}, pif.my_turn, 2'b00);
    tick;
    check({tag, "_we"}, board_we, 1);
    check({tag, "_row"}, board_row, r);
    check({tag, "_col"}, board_col, c);
    check({tag, "_val"}, board_val, (p == 0) ? 2'b01 : 2'b10);
    board[r][c] = (p == 0) ? 2'b01 : 2'b10;
    tick;
    check({tag, "_cap"}, capture_start, 1);
    check({tag, "_we_off"}, board_we, 0);
    tick;
    check({tag, "_cap_off"}, capture_start, 0);
    capture_done = 1'b1;
    tick;
    capture_done = 1'b0;
    check({tag, "_sw_turn"}, pif.my_turn, 2'b00);
    tick;
    check({tag, "_next_turn"}, pif.my_turn, (p == 0) ? 2'b10 : 2'b01);
    check({tag, "_count"}, move_count, exp_count);
  endtask

  task automatic try_illegal(input string tag, input int p, input logic [7:0] mv, input logic [1:0] exp_turn);
    drive_move(p, mv);
    tick;
    clear_strobes;
    check({tag, "_pulse"}, pif.illegal, 1);
    check({tag, "_no_we"}, board_we, 0);
    tick;
    check({tag, "_pulse_off"}, pif.illegal, 0);
    check({tag, "_turn"}, pif.my_turn, exp_turn);
    check({tag, "_no_we2"}, board_we, 0);
  endtask

  initial begin
    board          = '0;
    pif.move_in0   = 8'h00;
    pif.move_in1   = 8'h00;
    clear_strobes;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;

    check("rst_turn", pif.my_turn, 2'b01);
    check("rst_player", cur_player, 0);
    check("rst_over", game_over, 0);
    check("rst_count", move_count, 0);
    check("rst_we", board_we, 0);
    check("rst_cap", capture_start, 0);
    check("rst_ill", pif.illegal, 0);

    place("p0_44", 0, 8'h44, 8'd1);
    check("after_p0_player", cur_player, 1);

    // Black strobes while white holds the turn must be ignored
    pif.move_valid[0] = 1'b1;
    pif.pass_in[0]    = 1'b1;
    pif.move_in0      = 8'h00;
    tick;
    clear_strobes;
    check("ignore_other_turn", pif.my_turn, 2'b10);
    tick;
    check("ignore_other_we", board_we, 0);

    try_illegal("p1_occupied", 1, 8'h44, 2'b10);
    check("occupied_count", move_count, 1);

    place("p1_00", 1, 8'h00, 8'd2);
    try_illegal("p0_row9", 0, 8'h93, 2'b01);
    try_illegal("p0_col9", 0, 8'h09, 2'b01);

    // Pass and move together: the pass wins
    pif.pass_in[0] = 1'b1;
    drive_move(0, 8'h11);
    tick;
    clear_strobes;
    check("pass_sw_turn", pif.my_turn, 2'b00);
    check("pass_sw_we", board_we, 0);
    check("pass_sw_over", game_over, 0);
    tick;
    check("pass_next_turn", pif.my_turn, 2'b10);
    check("pass_next_we", board_we, 0);
    check("pass_count", move_count, 2);

    place("p1_88", 1, 8'h88, 8'd3);

    pif.pass_in[0] = 1'b1;
    tick;
    clear_strobes;
    check("streak_cleared_over", game_over, 0);
    tick;
    check("streak_cleared_turn", pif.my_turn, 2'b10);

    pif.pass_in[1] = 1'b1;
    tick;
    clear_strobes;
    check("two_pass_over", game_over, 1);
    check("two_pass_turn", pif.my_turn, 2'b00);

    pif.move_valid = 2'b11;
    pif.pass_in    = 2'b11;
    pif.move_in0   = 8'h55;
    pif.move_in1   = 8'h66;
    tick;
    clear_strobes;
    tick;
    check("over_sticky", game_over, 1);
    check("over_turn", pif.my_turn, 2'b00);
    check("over_we", board_we, 0);
    check("over_count", move_count, 3);

    // Reset while the capture engine is still busy
    board = '0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive_move(0, 8'h22);
    tick;
    clear_strobes;
    tick;
    tick;
    check("midcap_cap", capture_start, 1);
    check("midcap_count", move_count, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midcap_rst_player", cur_player, 0);
    check("midcap_rst_turn", pif.my_turn, 2'b01);
    check("midcap_rst_count", move_count, 0);
    check("midcap_rst_cap", capture_start, 0);
    check("midcap_rst_we", board_we, 0);
    capture_done = 1'b1;
    tick;
    capture_done = 1'b0;
    check("late_done_turn", pif.my_turn, 2'b01);
    tick;
    check("late_done_turn2", pif.my_turn, 2'b01);
    check("late_done_player", cur_player, 0);

`ifdef TURN_TIMEOUT_EN
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 1; i <= 14; i++) tick;
    check("to_early", pif.timeout, 0);
    check("to_early_turn", pif.my_turn, 2'b01);
    tick;
    check("to_fire", pif.timeout, 1);
    tick;
    check("to_fire_off", pif.timeout, 0);
    check("to_sw_turn", pif.my_turn, 2'b00);
    tick;
    check("to_next_turn", pif.my_turn, 2'b10);
    check("to_not_over", game_over, 0);
    for (int i = 1; i <= 15; i++) tick;
    check("to2_fire", pif.timeout, 1);
    tick;
    check("to2_over", game_over, 1);
    check("to2_turn", pif.my_turn, 2'b00);
    check("to2_pulse_off", pif.timeout, 0);
`else
    for (int i = 0; i < 20; i++) tick;
    check("no_timeout", pif.timeout, 0);
    check("no_timeout_turn", pif.my_turn, 2'b01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
